mips_bus_ram: RTL and testbench

- Memory-mapped word RAM slave sitting directly on the CPU bus interface (address/read/write/byteenable/writedata/readdata/waitrequest).
- Serves instruction and data accesses from mips_cpu_bus.
- Inserts a programmable number of wait states per transfer.
- Maps the reset vector region at ADDR_BASE, returns zero for the halt address 0, and flags protocol and range errors.

---
 rtl/mips_bus_ram_if.sv | 22 ++
 rtl/mips_bus_ram.sv | 135 +++++++++++++
 tb/tb_mips_bus_ram.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_ram_if.sv
// CPU-side bus between mips_cpu_bus and a memory-mapped slave.
// Carries the address/read/write/byteenable/writedata request, the slave response and a sticky error flag.
interface mips_bus_ram_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic [31:0] writedata;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        err;

  modport master (
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, err
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, err
  );
endinterface

// File: rtl/mips_bus_ram.sv
// Word RAM slave on the CPU bus.
// Each transfer is held off for WAIT_CYCLES cycles; address 0 reads as zero; range and protocol errors are flagged.
module mips_bus_ram #(
  parameter logic [31:0] ADDR_BASE   = 32'hBFC00000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter string       INIT_FILE   = "ram.txt"
) (
  input logic           clk,
  input logic           reset,
  mips_bus_ram_if.slave bus
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] readdata_q, readdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic            req;
  logic            accept;
  logic            addr_zero;
  logic            in_range;
  logic [29:0]     word_off;
  logic [IdxW-1:0] idx;
  logic [31:0]     lane_mask;
  logic [31:0]     rd_val;
  logic            mem_we;

  assign req       = bus.read | bus.write;
  assign addr_zero = (bus.address == 32'h0);
  assign word_off  = bus.address[31:2] - ADDR_BASE[31:2];
  assign in_range  = !addr_zero && (bus.address[31:2] >= ADDR_BASE[31:2]) &&
                     ({2'b00, word_off} < DEPTH_WORDS);
  assign idx       = word_off[IdxW-1:0];
  assign lane_mask = {{8{bus.byteenable[3]}}, {8{bus.byteenable[2]}},
                      {8{bus.byteenable[1]}}, {8{bus.byteenable[0]}}};

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (WAIT_CYCLES != 0) begin
      unique case (state_q)
        StIdle: begin
          if (req) begin
            state_d = StBusy;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end
        end
        StBusy: begin
          // A withdrawn request simply drops back to idle with no access.
          if (!req) begin
            state_d = StIdle;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.waitrequest = 1'b0;
    accept          = 1'b0;
    if (WAIT_CYCLES == 0) begin
      accept = req;
    end else begin
      unique case (state_q)
        StIdle: bus.waitrequest = req;
        StBusy: begin
          bus.waitrequest = req & (cnt_q != 4'd0);
          accept          = req & (cnt_q == 4'd0);
        end
        default: bus.waitrequest = req;
      endcase
    end
  end

  assign rd_val = in_range ? (mem[idx] & lane_mask) : 32'h0;
  // Gating with reset makes a reset on the would-be accept edge abort the write.
  assign mem_we = accept & reset & bus.write & in_range;

  always_comb begin
    readdata_d = readdata_q;
    err_d      = err_q;
    if (accept) begin
      if (bus.read && !bus.write) readdata_d = rd_val;
      if ((bus.read && bus.write) || (!addr_zero && !in_range)) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      readdata_q <= 32'h0;
      err_q      <= 1'b0;
    end else begin
      readdata_q <= readdata_d;
      err_q      <= err_d;
    end
  end

  // Memory has no reset so the boot image survives a CPU reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.byteenable[i]) mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mips_bus_ram.sv
// Scoreboard bench for mips_bus_ram: a 2-wait-state instance driven with directed and random
// transfers, plus a zero-wait instance for back-to-back reads.
module tb_mips_bus_ram;
  localparam logic [31:0] BASE  = 32'hBFC00000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_bus_ram_if b ();
  mips_bus_ram_if z ();

  mips_bus_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .INIT_FILE("")) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (b.slave)
  );

  mips_bus_ram #(.ADDR_BASE(BASE), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .INIT_FILE("")) dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (z.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model  [int];
  logic [31:0] model0 [int];
  logic [31:0] q  [$];
  logic [31:0] q0 [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  function automatic bit mapped(input logic [31:0] addr);
    return addr != 0 && addr >= BASE && ((addr - BASE) >> 2) < DEPTH;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] addr, input logic [3:0] be);
    int k;
    if (!mapped(addr)) return 32'h0;
    k = int'((addr - BASE) >> 2);
    return (model.exists(k) ? model[k] : 32'h0) & lanes(be);
  endfunction

  task automatic wr_model(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    int k;
    logic [31:0] m;
    if (!mapped(addr)) return;
    k = int'((addr - BASE) >> 2);
    m = lanes(be);
    model[k] = ((model.exists(k) ? model[k] : 32'h0) & ~m) | (wd & m);
  endtask

  // One full transfer on the 2-wait bus; returns the number of waitrequest-high cycles seen.
  task automatic xfer(input logic [31:0] addr, input logic rd, input logic wr,
                      input logic [3:0] be, input logic [31:0] wd, output int waits);
    @(negedge clk);
    b.address = addr; b.read = rd; b.write = wr; b.byteenable = be; b.writedata = wd;
    if (rd && !wr) q.push_back(rd_model(addr, be));
    if (wr) wr_model(addr, be, wd);
    waits = 0;
    #1;
    while (b.waitrequest && waits < 20) begin
      waits++;
      @(negedge clk);
      #1;
    end
    if (waits >= 20) check("xfer_timeout", 32'(waits), 32'd2);
    @(posedge clk);
    #1;
    b.read = 1'b0; b.write = 1'b0;
  endtask

  task automatic xfer_chk(input string name, input logic [31:0] addr, input logic rd,
                          input logic wr, input logic [3:0] be, input logic [31:0] wd);
    int w;
    xfer(addr, rd, wr, be, wd, w);
    check({name, "_waits"}, 32'(w), 32'd2);
  endtask

  // Monitors: compare readdata the cycle after every accepted read.
  initial begin
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (pend) begin
        if (q.size() == 0) check("sb_underflow", b.readdata, 32'hxxxxxxxx);
        else check("rdata", b.readdata, q.pop_front());
      end
      #1;
      pend = reset && b.read && !b.write && !b.waitrequest;
    end
  end

  initial begin
    logic pend;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (pend) begin
        if (q0.size() == 0) check("sb0_underflow", z.readdata, 32'hxxxxxxxx);
        else check("rdata0", z.readdata, q0.pop_front());
      end
      #1;
      pend = reset && z.read && !z.write && !z.waitrequest;
    end
  end

  initial begin
    logic [31:0] a, d, e;
    logic [3:0]  be;
    reset = 1'b0;
    b.address = 0; b.read = 0; b.write = 0; b.byteenable = 0; b.writedata = 0;
    z.address = 0; z.read = 0; z.write = 0; z.byteenable = 0; z.writedata = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rst_readdata", b.readdata, 32'h0);
    check("rst_err", {31'b0, b.err}, 32'h0);
    check("rst_wait", {31'b0, b.waitrequest}, 32'h0);

    // Preload words 0..15 through the bus.
    xfer_chk("init0", BASE, 0, 1, 4'hF, 32'h24020100);
    xfer_chk("init4", BASE + 32'h10, 0, 1, 4'hF, 32'h11223344);
    for (int i = 1; i < 16; i++) begin
      if (i != 4) xfer_chk("init", BASE + 32'(4 * i), 0, 1, 4'hF, $urandom);
    end

    xfer_chk("rd_w0", BASE, 1, 0, 4'hF, 0);
    check("err_clean", {31'b0, b.err}, 32'h0);

    xfer_chk("wr_lanes", BASE + 32'h10, 0, 1, 4'b0101, 32'hDEADBEEF);
    check("model_lanes", rd_model(BASE + 32'h10, 4'hF), 32'h11AD33EF);
    xfer_chk("rd_lanes", BASE + 32'h10, 1, 0, 4'hF, 0);

    xfer_chk("rd_hi", BASE, 1, 0, 4'b1100, 0);
    xfer_chk("rd_zero", 32'h0, 1, 0, 4'hF, 0);
    check("zero_err", {31'b0, b.err}, 32'h0);
    xfer_chk("wr_zero", 32'h0, 0, 1, 4'hF, 32'hFFFFFFFF);
    check("zero_wr_err", {31'b0, b.err}, 32'h0);

    for (int n = 0; n < 40; n++) begin
      a  = BASE + 32'(4 * $urandom_range(0, 15));
      be = 4'($urandom);
      d  = $urandom;
      if ($urandom_range(0, 1) == 1) xfer_chk("rnd_wr", a, 0, 1, be, d);
      else xfer_chk("rnd_rd", a, 1, 0, be, 0);
    end
    check("rnd_err", {31'b0, b.err}, 32'h0);

    xfer_chk("wr_oor", BASE + 32'h1000, 0, 1, 4'hF, 32'hCAFEF00D);
    check("oor_err", {31'b0, b.err}, 32'h1);
    xfer_chk("rd_after_oor", BASE, 1, 0, 4'hF, 0);
    xfer_chk("rd_oor", BASE - 32'h4, 1, 0, 4'hF, 0);

    e = rd_model(BASE + 32'h14, 4'hF);
    xfer_chk("rd_pre_rw", BASE + 32'h14, 1, 0, 4'hF, 0);
    xfer_chk("rw_both", BASE + 32'h4, 1, 1, 4'hF, 32'h5A5A1234);
    @(negedge clk);
    #1;
    check("rw_hold", b.readdata, e);
    check("rw_err", {31'b0, b.err}, 32'h1);
    xfer_chk("rd_rw", BASE + 32'h4, 1, 0, 4'hF, 0);

    // Reset lands on the edge where the write would have been accepted.
    @(negedge clk);
    b.address = BASE + 32'h8; b.write = 1'b1; b.byteenable = 4'hF; b.writedata = 32'h0BAD0BAD;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    b.write = 1'b0;
    #1;
    check("abort_readdata", b.readdata, 32'h0);
    check("abort_err", {31'b0, b.err}, 32'h0);
    xfer_chk("rd_abort", BASE + 32'h8, 1, 0, 4'hF, 0);

    // Request withdrawn mid-wait: no access and the FSM restarts from idle.
    @(negedge clk);
    b.address = BASE + 32'hC; b.write = 1'b1; b.byteenable = 4'hF; b.writedata = 32'h77777777;
    @(negedge clk);
    b.write = 1'b0;
    @(negedge clk);
    xfer_chk("rd_withdraw", BASE + 32'hC, 1, 0, 4'hF, 0);
    check("withdraw_err", {31'b0, b.err}, 32'h0);

    // Zero-wait instance: back-to-back writes then reads, one per cycle.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = $urandom;
      model0[i] = d;
      z.address = BASE + 32'(4 * i); z.write = 1'b1; z.read = 1'b0;
      z.byteenable = 4'hF; z.writedata = d;
      #1;
      check("w0_wr_wait", {31'b0, z.waitrequest}, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      z.address = BASE + 32'(4 * i); z.write = 1'b0; z.read = 1'b1;
      q0.push_back(model0[i]);
      #1;
      check("w0_rd_wait", {31'b0, z.waitrequest}, 32'h0);
    end
    @(negedge clk);
    z.read = 1'b0;
    repeat (3) @(negedge clk);

    check("sb_drain", 32'(q.size()), 32'd0);
    check("sb0_drain", 32'(q0.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
